wb_slave_sequencer: RTL and testbench
=====================================

Name: wb_slave_sequencer

Overview:
- Registered Wishbone transaction sequencer for the user project area.
- Accepts the single Wishbone master port from the management SoC and routes each transaction to one of two slaves: slave 0 is the user design, slave 1 is the debug register pair.
- Adds a per-transaction bus timeout, so an unresponsive or absent slave can never hang the management core.
- Counts timeouts and pulses an interrupt on each one; sits directly inside user_project_wrapper between the wbs_* pins and the slaves.

Parameters:
- DBG_TAG, 29'h601FFFF, value of adr[31:3] that selects the debug slave (slave 1); any other address selects slave 0.
- TIMEOUT, 255, number of ACTIVE cycles without slave ack before the sequencer terminates the transaction itself (legal range 1..65535).
- TO_DATA, 32'hDEAD_BEEF, read data returned on a timed-out transaction.
- CNT_W, 8, width of the saturating timeout counter.

Ports:
- wb_clk_i  in  1  Wishbone clock; the only clock.
- wb_rst_n_i  in  1  reset, asynchronous assert, active-low.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  master cycle, strobe, write enable.
- wbs_sel_i  in  4  master byte selects.
- wbs_adr_i, wbs_dat_i  in  32 each  master address and write data.
- wbs_ack_o  out  1  master acknowledge.
- wbs_dat_o  out  32  master read data.
- s_cyc_o  out  2  per-slave cycle, one-hot or zero.
- s_stb_o, s_we_o  out  1 each  shared slave strobe and write enable.
- s_sel_o  out  4  shared slave byte selects.
- s_adr_o, s_dat_o  out  32 each  shared slave address and write data, latched from the master.
- s_ack_i  in  2  per-slave acknowledge.
- s_dat_i  in  64  slave read data; slave n occupies bits [32n+31:32n].
- to_cnt_o  out  CNT_W  saturating count of timeouts.
- to_irq_o  out  1  one-cycle pulse per timeout.

Behaviour:
- Reset (asynchronous, wb_rst_n_i=0):
  - All outputs 0; FSM in IDLE; latches and counters cleared.
  - Reset asserted mid-transaction aborts it immediately with no ack.
- FSM states are IDLE, ACTIVE and RESP.
- IDLE:
  - When wbs_cyc_i & wbs_stb_i, latch adr, dat, sel and we.
  - Latch idx = (adr[31:3]==DBG_TAG).
  - Clear the timeout counter and go to ACTIVE.
  - Slave outputs remain 0 while in IDLE.
- ACTIVE:
  - Drive s_cyc_o[idx]=1 and s_stb_o=1; s_adr/dat/sel/we come from the latches and are stable for the whole state.
  - If s_ack_i[idx]: capture s_dat_i of slave idx into the read register, then go to RESP.
  - Otherwise, if the wait counter equals TIMEOUT-1: load TO_DATA, pulse to_irq_o, increment to_cnt_o (saturating at all-ones), then go to RESP.
  - Ack and timeout in the same cycle: the ack wins, with no timeout recorded.
  - s_ack_i of the non-selected slave is ignored in every state.
  - If wbs_cyc_i drops while ACTIVE (master abort): return to IDLE next cycle, drop slave cyc/stb, no ack, counter unchanged.
- RESP:
  - wbs_ack_o=1 for exactly one cycle; wbs_dat_o holds the captured data, also for writes (don't-care to the master).
  - Next state is IDLE, and IDLE requires one cycle before a new request is accepted, so a strobe held across RESP is never double-counted.
  - wbs_dat_o is held until the next RESP.
- Latency, with the request first sampled in cycle T0:
  - Slave strobe in T1; slave ack in Tk gives wbs_ack_o in Tk+1.
  - A zero-wait slave gives ack in T2.
  - A timeout gives ack in T0+TIMEOUT+1.
- Wait counter: 16-bit, increments each ACTIVE cycle without ack.

Decomposition:
- Package wb_seq_pkg holds:
  - the state enum (IDLE, ACTIVE, RESP);
  - the defaults for DBG_TAG, TO_DATA and TIMEOUT;
  - the slave index constants SLV_USER=0 and SLV_DBG=1.
- One natural sub-module, wb_seq_timeout: the wait counter plus the saturating to_cnt and irq pulse generation. The FSM and latches stay in the top.

Test Plan:
- Read of 0x3000_0000; slave 0 acks on the second ACTIVE cycle with 0x1234_5678 -> s_cyc_o=2'b01; wbs_ack_o at T3 with wbs_dat_o=0x1234_5678; to_cnt_o=0.
- Write 0xA5A5_A5A5 with sel=4'b0011 to 0x300F_FFF8 -> s_cyc_o=2'b10; s_dat_o=0xA5A5_A5A5 and s_sel_o=4'b0011 stable until ack; single wbs_ack_o pulse.
- Read to slave 0 with no ack, TIMEOUT=255 -> wbs_ack_o at T256 with 0xDEAD_BEEF; to_irq_o for one cycle; to_cnt_o=1. 256 such timeouts with CNT_W=8 -> to_cnt_o holds 255.
- Slave 1 acks while slave 0 is addressed, then slave 0 acks at the TIMEOUT-1 count -> the foreign ack is ignored; data is taken from slave 0; no timeout recorded.
- wbs_cyc_i dropped on the 3rd ACTIVE cycle -> s_cyc_o=0 next cycle; no wbs_ack_o; the next request proceeds normally.
- wb_rst_n_i pulsed low mid-ACTIVE, asynchronous to the clock edge -> all outputs 0 immediately; FSM in IDLE; no ack after release.

Source files
------------

// File: rtl/wb_seq_pkg.sv
// ---------------------------------------------------------------------------
// wb_seq_pkg
// Shared definitions for the Wishbone slave sequencer:
//   - seq_state_t : sequencer FSM states (IDLE, ACTIVE, RESP)
//   - default parameter values for the debug-slave tag, timeout length and
//     the read data returned on a timed-out transaction
//   - slave index constants and the wait-counter width
// ---------------------------------------------------------------------------
package wb_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESP   = 2'd2
  } seq_state_t;

  localparam logic [28:0] DBG_TAG_DEF = 29'h601_FFFF;
  localparam int unsigned TIMEOUT_DEF = 255;
  localparam logic [31:0] TO_DATA_DEF = 32'hDEAD_BEEF;

  localparam int unsigned NUM_SLV  = 2;
  localparam int unsigned SLV_USER = 0;
  localparam int unsigned SLV_DBG  = 1;

  localparam int unsigned WAIT_W = 16;

endpackage

// File: rtl/wb_seq_timeout.sv
// ---------------------------------------------------------------------------
// wb_seq_timeout
// Per-transaction wait counter plus the saturating timeout counter and the
// timeout interrupt pulse.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : new transaction accepted; clears the wait counter
//   waiting    : transaction outstanding this cycle with no slave ack
//   expired    : this waiting cycle is the last one allowed (combinational)
//   to_cnt     : saturating count of timeouts
//   to_irq     : one-cycle pulse following each timeout
// ---------------------------------------------------------------------------
module wb_seq_timeout
  import wb_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             waiting,
  output logic             expired,
  output logic [CNT_W-1:0] to_cnt,
  output logic             to_irq
);

  // The counter starts at 0 in the first ACTIVE cycle, so the limit is
  // TIMEOUT-1 to terminate after exactly TIMEOUT cycles.
  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              irq_reg;

  assign expired = waiting && (wait_reg == LIMIT);

  always_comb begin
    wait_next = wait_reg;
    cnt_next  = cnt_reg;
    if (start) begin
      wait_next = '0;
    end else if (waiting) begin
      wait_next = wait_reg + WAIT_W'(1);
    end
    if (expired && (cnt_reg != '1)) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_reg <= '0;
      cnt_reg  <= '0;
      irq_reg  <= 1'b0;
    end else begin
      wait_reg <= wait_next;
      cnt_reg  <= cnt_next;
      irq_reg  <= expired;
    end
  end

  assign to_cnt = cnt_reg;
  assign to_irq = irq_reg;

endmodule

// File: rtl/wb_slave_sequencer.sv
// ---------------------------------------------------------------------------
// wb_slave_sequencer
// Registered Wishbone sequencer: takes one master transaction at a time,
// routes it to the user slave (0) or the debug slave (1), and terminates it
// itself with TO_DATA if the slave does not ack within TIMEOUT cycles.
// Ports:
//   wb_clk_i, wb_rst_n_i       : clock, asynchronous active-low reset
//   wbs_cyc/stb/we/sel/adr/dat_i : master request
//   wbs_ack_o, wbs_dat_o        : master response (ack pulse, read data)
//   s_cyc_o[1:0]                : per-slave cycle, one-hot or zero
//   s_stb/we/sel/adr/dat_o      : shared slave request, from the latches
//   s_ack_i[1:0], s_dat_i[63:0] : per-slave ack and read data
//   to_cnt_o, to_irq_o          : saturating timeout count, timeout pulse
// ---------------------------------------------------------------------------
module wb_slave_sequencer
  import wb_seq_pkg::*;
#(
  parameter logic [28:0] DBG_TAG = DBG_TAG_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter logic [31:0] TO_DATA = TO_DATA_DEF,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic [1:0]       s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [3:0]       s_sel_o,
  output logic [31:0]      s_adr_o,
  output logic [31:0]      s_dat_o,
  input  logic [1:0]       s_ack_i,
  input  logic [63:0]      s_dat_i,
  output logic [CNT_W-1:0] to_cnt_o,
  output logic             to_irq_o
);

  seq_state_t  state_reg, state_next;
  logic [31:0] adr_reg, dat_reg, rd_data_reg, rd_data_next;
  logic [3:0]  sel_reg;
  logic        we_reg, idx_reg;

  logic        req, in_active, is_dbg, slv_ack, abort, start, waiting, expired;
  logic [31:0] slv_rdata;

  assign req       = wbs_cyc_i & wbs_stb_i;
  assign in_active = (state_reg == ACTIVE);
  assign is_dbg    = (wbs_adr_i[31:3] == DBG_TAG);
  // Only the addressed slave's ack and data are ever looked at.
  assign slv_ack   = s_ack_i[idx_reg];
  assign slv_rdata = s_dat_i[{idx_reg, 5'd0} +: 32];
  assign abort     = in_active & ~wbs_cyc_i;
  assign start     = (state_reg == IDLE) & req;
  assign waiting   = in_active & wbs_cyc_i & ~slv_ack;

  wb_seq_timeout #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_n_i),
    .start   (start),
    .waiting (waiting),
    .expired (expired),
    .to_cnt  (to_cnt_o),
    .to_irq  (to_irq_o)
  );

  // Master abort beats ack, and ack beats timeout (expired is already
  // qualified by the absence of ack).
  always_comb begin
    state_next   = state_reg;
    rd_data_next = rd_data_reg;
    unique case (state_reg)
      IDLE: begin
        if (req) state_next = ACTIVE;
      end
      ACTIVE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (slv_ack) begin
          state_next   = RESP;
          rd_data_next = slv_rdata;
        end else if (expired) begin
          state_next   = RESP;
          rd_data_next = TO_DATA;
        end
      end
      RESP: begin
        // Always pass through IDLE so a strobe held over the ack cycle is
        // not taken as a second request.
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_reg   <= IDLE;
      adr_reg     <= '0;
      dat_reg     <= '0;
      sel_reg     <= '0;
      we_reg      <= 1'b0;
      idx_reg     <= 1'b0;
      rd_data_reg <= '0;
    end else begin
      state_reg   <= state_next;
      rd_data_reg <= rd_data_next;
      if (start) begin
        adr_reg <= wbs_adr_i;
        dat_reg <= wbs_dat_i;
        sel_reg <= wbs_sel_i;
        we_reg  <= wbs_we_i;
        idx_reg <= is_dbg ? 1'(SLV_DBG) : 1'(SLV_USER);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLV; gi++) begin : g_slv_cyc
      assign s_cyc_o[gi] = in_active && (idx_reg == 1'(gi));
    end
  endgenerate

  // Slave-side request is visible only while the transaction is outstanding.
  assign s_stb_o = in_active;
  assign s_we_o  = in_active & we_reg;
  assign s_sel_o = in_active ? sel_reg : '0;
  assign s_adr_o = in_active ? adr_reg : '0;
  assign s_dat_o = in_active ? dat_reg : '0;

  assign wbs_ack_o = (state_reg == RESP);
  assign wbs_dat_o = rd_data_reg;

endmodule

// File: tb/tb_wb_slave_sequencer.sv
// ---------------------------------------------------------------------------
// tb_wb_slave_sequencer
// Self-checking bench: directed vector table, randomized transactions
// against a behavioural model, timeout-counter saturation and a mid-
// transaction asynchronous reset.
// ---------------------------------------------------------------------------
module tb_wb_slave_sequencer;

  localparam int          TO_CYC = 255;
  localparam logic [28:0] TAG    = 29'h601_FFFF;
  localparam logic [31:0] TOD    = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = '0;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [1:0]  s_cyc_o;
  logic        s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [1:0]  s_ack_i = '0;
  logic [63:0] s_dat_i = '0;
  logic [7:0]  to_cnt_o;
  logic        to_irq_o;

  always #5 clk = ~clk;

  wb_slave_sequencer #(
    .DBG_TAG (TAG),
    .TIMEOUT (TO_CYC),
    .TO_DATA (TOD),
    .CNT_W   (8)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_dat_o  (wbs_dat_o),
    .s_cyc_o    (s_cyc_o),
    .s_stb_o    (s_stb_o),
    .s_we_o     (s_we_o),
    .s_sel_o    (s_sel_o),
    .s_adr_o    (s_adr_o),
    .s_dat_o    (s_dat_o),
    .s_ack_i    (s_ack_i),
    .s_dat_i    (s_dat_i),
    .to_cnt_o   (to_cnt_o),
    .to_irq_o   (to_irq_o)
  );

  int          n_pass  = 0;
  int          n_total = 0;
  int          txn_id  = 0;
  logic [7:0]  exp_cnt = '0;
  logic [31:0] held    = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h", name, act, exp);
  endtask

  // Behavioural outcome of one transaction. ack_cyc / abort_cyc are the
  // ACTIVE-cycle numbers (1 = first) in which the addressed slave acks /
  // the master drops cyc; 0 means never.
  task automatic model(input logic [31:0] adr, input int ack_cyc, input int abort_cyc,
                       input logic [31:0] sdat, output int e_ack, output logic [31:0] e_dat,
                       output logic [1:0] e_cyc, output int e_to);
    bit ack_ok;
    int window;
    ack_ok = (ack_cyc >= 1) && (ack_cyc <= TO_CYC);
    window = ack_ok ? ack_cyc : TO_CYC;
    e_cyc  = (adr[31:3] == TAG) ? 2'b10 : 2'b01;
    if (abort_cyc > 0 && abort_cyc <= window) begin
      e_ack = 0; e_dat = held; e_to = 0;
    end else if (ack_ok) begin
      e_ack = ack_cyc + 1; e_dat = sdat; e_to = 0;
    end else begin
      e_ack = TO_CYC + 1; e_dat = TOD; e_to = 1;
    end
  endtask

  // Runs one transaction starting in an IDLE cycle (T0) and checks it.
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int ack_cyc, input int foreign_cyc,
                         input int abort_cyc, input logic [31:0] sdat, input int exp_ack,
                         input logic [31:0] exp_dat, input logic [1:0] exp_cyc, input int exp_to);
    int          tgt, first_ack, ack_n, irq_n, bus_err, last_active, stop;
    logic        act;
    logic [31:0] got_dat;
    tgt = (adr[31:3] == TAG) ? 1 : 0;
    first_ack = 0; ack_n = 0; irq_n = 0; bus_err = 0; got_dat = '0;
    last_active = (exp_ack > 0) ? exp_ack - 1 : abort_cyc;
    stop = ((exp_ack > 0) ? exp_ack : abort_cyc) + 2;
    if (stop > TO_CYC + 4) stop = TO_CYC + 4;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel; s_ack_i = '0;
    for (int n = 1; n <= stop; n++) begin
      @(posedge clk); #1;
      act = (n <= last_active);
      if (s_cyc_o !== (act ? exp_cyc : 2'b00) || s_stb_o !== act) bus_err++;
      if (act && (s_adr_o !== adr || s_dat_o !== dat || s_sel_o !== sel || s_we_o !== we))
        bus_err++;
      if (wbs_ack_o === 1'b1) begin
        ack_n++;
        if (first_ack == 0) begin
          first_ack = n;
          got_dat   = wbs_dat_o;
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      end
      if (to_irq_o === 1'b1) irq_n++;
      s_ack_i = '0;
      s_dat_i = {$urandom(), $urandom()};
      if (n == ack_cyc) begin
        s_ack_i[tgt] = 1'b1;
        s_dat_i[tgt*32 +: 32] = sdat;
      end
      if (n == foreign_cyc) s_ack_i[1-tgt] = 1'b1;
      if (n == abort_cyc) begin
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      end
    end
    s_ack_i = '0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    if (exp_to != 0) exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
    held = exp_dat;
    chk("ack_cycle", first_ack, exp_ack);
    chk("ack_pulses", ack_n, (exp_ack > 0) ? 1 : 0);
    if (exp_ack > 0) chk("ack_data", got_dat, exp_dat);
    chk("dat_hold", wbs_dat_o, exp_dat);
    chk("irq_pulses", irq_n, exp_to);
    chk("to_cnt", {24'd0, to_cnt_o}, {24'd0, exp_cnt});
    chk("slave_bus", bus_err, 0);
    $display("txn %0d: we=%0b adr=%08h ack_at=T%0d rdata=%08h to_cnt=%0d",
             txn_id, we, adr, first_ack, got_dat, to_cnt_o);
    txn_id++;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          ack_cyc;
    int          foreign_cyc;
    int          abort_cyc;
    logic [31:0] sdat;
    int          exp_ack;
    logic [31:0] exp_dat;
    logic [1:0]  exp_cyc;
    int          exp_to;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          e_ack, e_to, bad;
    logic [31:0] e_dat;
    logic [1:0]  e_cyc;

    //        we  adr            dat            sel      ack  frn  abt  sdat           exp_ack exp_dat     cyc    to
    vecs[0] = '{1'b0, 32'h3000_0000, 32'h0,         4'hF,    2,   0,   0, 32'h1234_5678, 3,      32'h1234_5678, 2'b01, 0};
    vecs[1] = '{1'b1, 32'h300F_FFF8, 32'hA5A5_A5A5, 4'b0011, 4,   0,   0, 32'h0BAD_F00D, 5,      32'h0BAD_F00D, 2'b10, 0};
    vecs[2] = '{1'b0, 32'h3000_0010, 32'h0,         4'hF,    0,   0,   0, 32'h0,         256,    32'hDEAD_BEEF, 2'b01, 1};
    vecs[3] = '{1'b0, 32'h3000_0020, 32'h0,         4'hF,    255, 3,   0, 32'hC0DE_0001, 256,    32'hC0DE_0001, 2'b01, 0};
    vecs[4] = '{1'b0, 32'h3000_0030, 32'h0,         4'hF,    0,   0,   3, 32'h0,         0,      32'hC0DE_0001, 2'b01, 0};
    vecs[5] = '{1'b0, 32'h300F_FFFC, 32'h0,         4'hF,    1,   0,   0, 32'h5555_AAAA, 2,      32'h5555_AAAA, 2'b10, 0};
    vecs[6] = '{1'b1, 32'h300F_FFF0, 32'h1111_2222, 4'b1000, 1,   1,   0, 32'h7777_8888, 2,      32'h7777_8888, 2'b01, 0};

    // Power-on reset
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl", {14'd0, s_cyc_o, s_stb_o, s_we_o, s_sel_o, wbs_ack_o, to_irq_o, to_cnt_o}, 32'd0);
    chk("reset_rdat", wbs_dat_o, 32'd0);
    chk("reset_sadr", s_adr_o, 32'd0);
    chk("reset_sdat", s_dat_o, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 7; i++)
      run_txn(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].ack_cyc,
              vecs[i].foreign_cyc, vecs[i].abort_cyc, vecs[i].sdat, vecs[i].exp_ack,
              vecs[i].exp_dat, vecs[i].exp_cyc, vecs[i].exp_to);

    // Randomized transactions
    for (int i = 0; i < 40; i++) begin
      logic        r_we;
      logic [31:0] r_adr, r_dat, r_sdat;
      logic [3:0]  r_sel;
      int          r_ack, r_frn, r_abt;
      r_we   = 1'($urandom_range(0, 1));
      r_adr  = ($urandom_range(0, 1) == 1) ? {TAG, 3'($urandom_range(0, 7))} : $urandom();
      r_dat  = $urandom();
      r_sdat = $urandom();
      r_sel  = 4'($urandom_range(0, 15));
      r_ack  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8);
      r_frn  = $urandom_range(0, 8);
      r_abt  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 8) : 0;
      model(r_adr, r_ack, r_abt, r_sdat, e_ack, e_dat, e_cyc, e_to);
      run_txn(r_we, r_adr, r_dat, r_sel, r_ack, r_frn, r_abt, r_sdat, e_ack, e_dat, e_cyc, e_to);
    end

    // Drive the timeout counter to all-ones, then one more timeout must hold it
    for (int i = 0; i < 300 && exp_cnt != 8'hFF; i++) begin
      model(32'h3000_1000, 0, 0, 32'h0, e_ack, e_dat, e_cyc, e_to);
      run_txn(1'b0, 32'h3000_1000, 32'h0, 4'hF, 0, 0, 0, 32'h0, e_ack, e_dat, e_cyc, e_to);
    end
    model(32'h3000_1008, 0, 0, 32'h0, e_ack, e_dat, e_cyc, e_to);
    run_txn(1'b0, 32'h3000_1008, 32'h0, 4'hF, 0, 0, 0, 32'h0, e_ack, e_dat, e_cyc, e_to);
    chk("to_cnt_saturated", {24'd0, to_cnt_o}, 32'h0000_00FF);

    // Asynchronous reset in the middle of an ACTIVE phase
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = 32'h3000_0000; wbs_sel_i = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_ctl", {14'd0, s_cyc_o, s_stb_o, s_we_o, s_sel_o, wbs_ack_o, to_irq_o, to_cnt_o}, 32'd0);
    chk("midrst_rdat", wbs_dat_o, 32'd0);
    chk("midrst_sadr", s_adr_o, 32'd0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    s_ack_i = 2'b11;
    @(negedge clk) rst_n = 1'b1;
    bad = 0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      if (wbs_ack_o !== 1'b0 || s_stb_o !== 1'b0 || s_cyc_o !== 2'b00) bad++;
    end
    s_ack_i = '0;
    chk("post_reset_quiet", bad, 0);
    exp_cnt = '0;
    held    = '0;
    model(32'h3000_0100, 1, 0, 32'hFACE_0042, e_ack, e_dat, e_cyc, e_to);
    run_txn(1'b0, 32'h3000_0100, 32'h0, 4'hF, 1, 0, 0, 32'hFACE_0042, e_ack, e_dat, e_cyc, e_to);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
